pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised successor to the combinational next-PC logic. Holds the architectural PC register
//  and selects the next PC. Runs a req/ack fetch handshake to instruction memory, honours pipeline
//  stall, and adds trap entry/return with an internal MEPC register. Sits between the
//  control/ALU datapath and instruction memory.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 PC loaded on reset
//  TRAP_VEC  32'h0000_0100 target for NPC_TRAP (and misalign trap when enabled)
// PORTS
//  clk        in   1     clock, rising edge
//  rstn       in   1     asynchronous active-low reset
//  stall      in   1     hold current instruction; PC must not advance
//  NPCOp      in   3     next-PC op; sampled only when inst_valid=1 and stall=0
//  IMM        in   XLEN  branch/jump offset
//  aluout     in   XLEN  JALR target
//  if_req     out  1     fetch request to instruction memory
//  if_addr    out  XLEN  fetch address (= PC while if_req=1)
//  if_ack     in   1     memory accepts req and returns if_rdata in the same cycle
//  if_rdata   in   32    fetched instruction word
//  inst       out  32    instruction currently in execute
//  inst_valid out  1     inst is valid and executing
//  PC         out  XLEN  current PC (address of inst)
//  mepc       out  XLEN  saved trap PC
//  misalign   out  1     1-cycle pulse on misaligned-target trap (tied 0 unless macro set)
// BEHAVIOUR
//  - Op codes: PLUS4=000, BRANCH=001, JUMP=010, JALR=100, TRAP=101, MRET=110; others act as PLUS4.
//  - Targets:
//    - PLUS4 = PC+4; BRANCH/JUMP = PC+IMM; JALR = aluout & ~1.
//    - TRAP = TRAP_VEC, mepc<=PC; MRET = mepc.
//    - All sums are modulo 2^XLEN (wrap silently).
//  - FSM states RST, FETCH, EXEC:
//    - RST: while rstn=0, PC=RESET_PC, mepc=0, inst=0, inst_valid=0, if_req=0, misalign=0.
//      First clk edge after release -> FETCH.
//    - FETCH: if_req=1, if_addr=PC, inst_valid=0.
//      if_ack=1 -> inst<=if_rdata, go EXEC (1 cycle min fetch latency).
//      if_ack=0 -> stay; PC, if_addr stable.
//    - EXEC: inst_valid=1, if_req=0.
//      stall=1 -> stay; PC, inst, mepc held.
//      stall=0 -> PC<=target(NPCOp), go FETCH.
//  - if_ack outside FETCH is ignored. stall in FETCH has no effect.
//  - mepc is written only by TRAP (or misalign trap). MRET does not modify mepc.
//  - TRAP immediately followed by MRET returns to the trapping PC (not PC+4).
//  - rstn low mid-fetch or mid-stall: all state forced to reset values asynchronously;
//    a pending if_ack in that cycle is discarded.
//  - Steady-state throughput: one instruction per 2 cycles with if_ack tied 1.
// CONFIGURATION
//  NPC_MISALIGN_TRAP_EN defined:
//    - If the BRANCH/JUMP/JALR target has target[1:0]!=0, PC<=TRAP_VEC and mepc<=PC.
//    - misalign pulses 1 for the EXEC->FETCH cycle.
//  NPC_MISALIGN_TRAP_EN undefined:
//    - Target bits [1:0] are forced to 00 and misalign is constant 0.
//  TRAP/MRET/PLUS4 targets are never checked.
// TESTING
//  1. Reset release with if_ack=1, NPCOp=000 for 4 instrs -> if_addr 0,4,8,C; inst_valid alternates 0/1.
//  2. PC=0x20, BRANCH, IMM=0xFFFFFFF0 -> next if_addr 0x10.
//     PC=0xFFFFFFFC, PLUS4 -> 0x0 (wrap).
//  3. EXEC with stall=1 for 3 cycles, then JALR aluout=0x45 -> PC holds 3 cycles,
//     then if_addr=0x44 (macro off).
//  4. PC=0x40, TRAP -> if_addr=0x100, mepc=0x40; later MRET -> if_addr=0x40, mepc unchanged.
//  5. FETCH with if_ack=0 for 5 cycles, then rstn pulsed low -> if_req drops immediately,
//     PC=RESET_PC, inst_valid=0.
//  6. Macro on: PC=0x8, JUMP, IMM=0x6 -> PC=0x100, mepc=0x8, misalign=1 for one cycle;
//     macro off: PC=0xC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register, next-PC selection, req/ack
// instruction fetch handshake, pipeline stall and trap entry/return via MEPC.
// Optional feature macro: NPC_MISALIGN_TRAP_EN. When it is defined, a
// misaligned BRANCH/JUMP/JALR target traps to TRAP_VEC. When it is undefined,
// the low two target bits are cleared instead.
module pc_fetch_unit #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter logic [XLEN-1:0]     TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic [2:0]      NPCOp,
    input  logic [XLEN-1:0] IMM,
    input  logic [XLEN-1:0] aluout,
    output logic            if_req,
    output logic [XLEN-1:0] if_addr,
    input  logic            if_ack,
    input  logic [31:0]     if_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] mepc,
    output logic            misalign
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] next_pc;
    logic            take_trap;
    logic            chk_align;
`ifdef NPC_MISALIGN_TRAP_EN
    logic            mis_trap;
`endif

    // The fetch address is always the architectural PC; memory only looks at it while if_req=1.
    assign if_addr = PC;

    // Next-PC selection from NPCOp, including trap redirection and target alignment handling.
    always_comb begin
        next_pc   = PC + XLEN'(4);
        take_trap = 1'b0;
        chk_align = 1'b0;
`ifdef NPC_MISALIGN_TRAP_EN
        mis_trap  = 1'b0;
`endif
        case (NPCOp)
            3'b001, 3'b010: begin
                next_pc   = PC + IMM;
                chk_align = 1'b1;
            end
            3'b100: begin
                next_pc   = aluout & ~XLEN'(1);
                chk_align = 1'b1;
            end
            3'b101: begin
                next_pc   = TRAP_VEC;
                take_trap = 1'b1;
            end
            3'b110:  next_pc = mepc;
            default: next_pc = PC + XLEN'(4);
        endcase
`ifdef NPC_MISALIGN_TRAP_EN
        if (chk_align && (next_pc[1:0] != 2'b00)) begin
            next_pc   = TRAP_VEC;
            take_trap = 1'b1;
            mis_trap  = 1'b1;
        end
`else
        if (chk_align) begin
            next_pc[1:0] = 2'b00;
        end
`endif
    end

    // Fetch/execute sequencer with registered handshake and valid outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_RST;
            PC         <= RESET_PC;
            mepc       <= '0;
            inst       <= '0;
            if_req     <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    state  <= S_FETCH;
                    if_req <= 1'b1;
                end
                S_FETCH: begin
                    if (if_ack) begin
                        inst       <= if_rdata;
                        state      <= S_EXEC;
                        if_req     <= 1'b0;
                        inst_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        PC         <= next_pc;
                        if (take_trap) begin
                            mepc <= PC;
                        end
                        state      <= S_FETCH;
                        if_req     <= 1'b1;
                        inst_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_RST;
                    if_req     <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef NPC_MISALIGN_TRAP_EN
    // One-cycle misalign pulse coinciding with the first FETCH cycle after the trapping instruction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (state == S_EXEC) && !stall && mis_trap;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
